// File: rtl/cop_pkg.sv
// Shared definitions for the coprocessor request/response channel:
// word widths, instruction field positions and the request-entry layout.
package cop_pkg;

  localparam int COP_INST_WIDTH = 32;
  localparam int COP_REG_WIDTH  = 32;
  localparam int COP_XD_BIT     = 14;
  localparam int COP_RD_LSB     = 7;
  localparam int COP_RD_W       = 5;

  typedef struct packed {
    logic [COP_INST_WIDTH-1:0] insn;
    logic [COP_REG_WIDTH-1:0]  rs1;
    logic [COP_REG_WIDTH-1:0]  rs2;
    logic [COP_REG_WIDTH-1:0]  rs3;
  } cop_req_t;

  // Instruction expects a result to be written back
  function automatic logic insn_xd(input logic [COP_INST_WIDTH-1:0] insn);
    return insn[COP_XD_BIT];
  endfunction

  // Destination register field
  function automatic logic [COP_RD_W-1:0] insn_rd(input logic [COP_INST_WIDTH-1:0] insn);
    return insn[COP_RD_LSB +: COP_RD_W];
  endfunction

endpackage

// File: rtl/cop_sync_fifo.sv
// Single-clock FIFO with full/empty flags derived from an extra pointer
// bit. DEPTH must be a power of two. Push when full and pop when empty
// are ignored. Storage is not reset; only the pointers are.
module cop_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & !full;
  assign do_pop  = pop & !empty;
  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer advance; wraps naturally modulo 2*DEPTH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // Entry storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/cop_issuer.sv
// Host-side initiator for the gnpu coprocessor channel. Buffers dispatched
// instructions, issues them in order, tracks destination registers of
// result-producing instructions and steers responses back to writeback.
// Optional build macro: COP_ISSUER_TIMEOUT_EN enables the response watchdog.
module cop_issuer
  import cop_pkg::*;
#(
  parameter int REQ_DEPTH      = 4,
  parameter int TAG_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      disp_vld_i,
  output logic                      disp_rdy_o,
  input  logic [COP_INST_WIDTH-1:0] disp_insn_i,
  input  logic [COP_REG_WIDTH-1:0]  disp_rs1_data_i,
  input  logic [COP_REG_WIDTH-1:0]  disp_rs2_data_i,
  input  logic [COP_REG_WIDTH-1:0]  disp_rs3_data_i,
  output logic                      cpu_tpu_req_vld_o,
  input  logic                      cpu_tpu_req_rdy_i,
  output logic [COP_INST_WIDTH-1:0] cpu_tpu_req_insn_o,
  output logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs1_data_o,
  output logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs2_data_o,
  output logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs3_data_o,
  input  logic                      cpu_tpu_resp_vld_i,
  output logic                      cpu_tpu_resp_rdy_o,
  input  logic [COP_REG_WIDTH-1:0]  cpu_tpu_resp_data_i,
  output logic                      wb_vld_o,
  input  logic                      wb_rdy_i,
  output logic [4:0]                wb_rd_o,
  output logic [COP_REG_WIDTH-1:0]  wb_data_o,
  output logic                      busy_o,
  output logic                      err_o,
  output logic                      timeout_o
);

  cop_req_t              req_wdata;
  cop_req_t              req_head;
  cop_req_t              req_out;
  logic                  req_full;
  logic                  req_empty;
  logic                  req_push;
  logic                  req_fire;
  logic                  head_xd;
  logic [COP_RD_W-1:0]   tag_head;
  logic                  tag_full;
  logic                  tag_empty;
  logic                  tag_push;
  logic                  tag_pop;

  assign req_wdata  = '{insn: disp_insn_i, rs1: disp_rs1_data_i,
                        rs2: disp_rs2_data_i, rs3: disp_rs3_data_i};
  assign disp_rdy_o = !req_full;
  assign req_push   = disp_vld_i & !req_full;

  cop_sync_fifo #(
    .DATA_W ($bits(cop_req_t)),
    .DEPTH  (REQ_DEPTH)
  ) u_req_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (req_push),
    .wdata (req_wdata),
    .pop   (req_fire),
    .rdata (req_head),
    .full  (req_full),
    .empty (req_empty)
  );

  // A result-producing request may only issue when its tag has a slot
  assign head_xd           = !req_empty & insn_xd(req_head.insn);
  assign cpu_tpu_req_vld_o = !req_empty & !(head_xd & tag_full);
  assign req_fire          = cpu_tpu_req_vld_o & cpu_tpu_req_rdy_i;
  assign tag_push          = req_fire & head_xd;

  // Payload reads as zero while nothing is queued (stale storage hidden)
  assign req_out                = req_empty ? '0 : req_head;
  assign cpu_tpu_req_insn_o     = req_out.insn;
  assign cpu_tpu_req_rs1_data_o = req_out.rs1;
  assign cpu_tpu_req_rs2_data_o = req_out.rs2;
  assign cpu_tpu_req_rs3_data_o = req_out.rs3;

  cop_sync_fifo #(
    .DATA_W (COP_RD_W),
    .DEPTH  (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tag_push),
    .wdata (insn_rd(req_head.insn)),
    .pop   (tag_pop),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty)
  );

  // Response steering: pass through to writeback when a tag is pending,
  // otherwise accept and drop the response
  always_comb begin
    cpu_tpu_resp_rdy_o = 1'b1;
    wb_vld_o           = 1'b0;
    if (!tag_empty) begin
      cpu_tpu_resp_rdy_o = wb_rdy_i;
      wb_vld_o           = cpu_tpu_resp_vld_i;
    end
  end

  assign tag_pop   = wb_vld_o & wb_rdy_i;
  assign wb_rd_o   = tag_empty ? '0 : tag_head;
  assign wb_data_o = cpu_tpu_resp_data_i;
  assign busy_o    = !req_empty | !tag_empty;

  // Sticky flag for a response that arrives with no outstanding tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             err_o <= 1'b0;
    else if (cpu_tpu_resp_vld_i & tag_empty) err_o <= 1'b1;
  end

`ifdef COP_ISSUER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;

  // Watchdog: counts cycles since the last tag pop while tags are pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_o <= 1'b0;
    end else begin
      if (tag_empty || tag_pop)                  wd_cnt <= '0;
      else if (wd_cnt != CNT_W'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == CNT_W'(TIMEOUT_CYCLES))      timeout_o <= 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_cop_issuer.sv
// Scoreboard bench for cop_issuer: expected requests and writeback tags are
// queued when stimulus is driven and compared when the DUT fires them.
module tb_cop_issuer;
  import cop_pkg::*;

  localparam int TO = 16;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      disp_vld_i = 1'b0;
  logic                      disp_rdy_o;
  logic [COP_INST_WIDTH-1:0] disp_insn_i = '0;
  logic [COP_REG_WIDTH-1:0]  disp_rs1_data_i = '0;
  logic [COP_REG_WIDTH-1:0]  disp_rs2_data_i = '0;
  logic [COP_REG_WIDTH-1:0]  disp_rs3_data_i = '0;
  logic                      cpu_tpu_req_vld_o;
  logic                      cpu_tpu_req_rdy_i = 1'b0;
  logic [COP_INST_WIDTH-1:0] cpu_tpu_req_insn_o;
  logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs1_data_o;
  logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs2_data_o;
  logic [COP_REG_WIDTH-1:0]  cpu_tpu_req_rs3_data_o;
  logic                      cpu_tpu_resp_vld_i = 1'b0;
  logic                      cpu_tpu_resp_rdy_o;
  logic [COP_REG_WIDTH-1:0]  cpu_tpu_resp_data_i = '0;
  logic                      wb_vld_o;
  logic                      wb_rdy_i = 1'b0;
  logic [4:0]                wb_rd_o;
  logic [COP_REG_WIDTH-1:0]  wb_data_o;
  logic                      busy_o;
  logic                      err_o;
  logic                      timeout_o;

  int       checks = 0;
  int       errors = 0;
  cop_req_t exp_req_q[$];
  logic [4:0] exp_rd_q[$];
  cop_req_t obs;

  assign obs = {cpu_tpu_req_insn_o, cpu_tpu_req_rs1_data_o,
                cpu_tpu_req_rs2_data_o, cpu_tpu_req_rs3_data_o};

  always #5 clk = ~clk;

  cop_issuer #(
    .REQ_DEPTH      (4),
    .TAG_DEPTH      (4),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .disp_vld_i             (disp_vld_i),
    .disp_rdy_o             (disp_rdy_o),
    .disp_insn_i            (disp_insn_i),
    .disp_rs1_data_i        (disp_rs1_data_i),
    .disp_rs2_data_i        (disp_rs2_data_i),
    .disp_rs3_data_i        (disp_rs3_data_i),
    .cpu_tpu_req_vld_o      (cpu_tpu_req_vld_o),
    .cpu_tpu_req_rdy_i      (cpu_tpu_req_rdy_i),
    .cpu_tpu_req_insn_o     (cpu_tpu_req_insn_o),
    .cpu_tpu_req_rs1_data_o (cpu_tpu_req_rs1_data_o),
    .cpu_tpu_req_rs2_data_o (cpu_tpu_req_rs2_data_o),
    .cpu_tpu_req_rs3_data_o (cpu_tpu_req_rs3_data_o),
    .cpu_tpu_resp_vld_i     (cpu_tpu_resp_vld_i),
    .cpu_tpu_resp_rdy_o     (cpu_tpu_resp_rdy_o),
    .cpu_tpu_resp_data_i    (cpu_tpu_resp_data_i),
    .wb_vld_o               (wb_vld_o),
    .wb_rdy_i               (wb_rdy_i),
    .wb_rd_o                (wb_rd_o),
    .wb_data_o              (wb_data_o),
    .busy_o                 (busy_o),
    .err_o                  (err_o),
    .timeout_o              (timeout_o)
  );

  function automatic cop_req_t mk_req(input logic xd, input logic [4:0] rd,
                                      input logic [31:0] rs1);
    cop_req_t r;
    r.insn             = '0;
    r.insn[6:0]        = 7'h0B;
    r.insn[11:7]       = rd;
    r.insn[COP_XD_BIT] = xd;
    r.insn[31:25]      = 7'($urandom);
    r.rs1              = rs1;
    r.rs2              = $urandom;
    r.rs3              = $urandom;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input cop_req_t r);
    disp_vld_i      = 1'b1;
    disp_insn_i     = r.insn;
    disp_rs1_data_i = r.rs1;
    disp_rs2_data_i = r.rs2;
    disp_rs3_data_i = r.rs3;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({disp_rdy_o, cpu_tpu_req_vld_o, cpu_tpu_resp_rdy_o, wb_vld_o, busy_o, err_o, timeout_o} !== 7'b1010000) begin
      errors++;
      $display("FAIL reset_flags got %b want 1010000", {disp_rdy_o, cpu_tpu_req_vld_o, cpu_tpu_resp_rdy_o, wb_vld_o, busy_o, err_o, timeout_o});
    end
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL reset_payload got %h want 0", obs);
    end
    checks++;
    if (wb_rd_o !== 5'd0) begin
      errors++;
      $display("FAIL reset_wb_rd got %0d want 0", wb_rd_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_xd();
    cop_req_t r, e;
    logic [4:0] erd;
    tick();
    r = mk_req(1'b1, 5'd5, 32'h11);
    drive_disp(r);
    cpu_tpu_req_rdy_i = 1'b1;
    @(negedge clk);
    checks++;
    if (disp_rdy_o !== 1'b1 || cpu_tpu_req_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL single_dispatch got rdy=%b vld=%b want rdy=1 vld=0", disp_rdy_o, cpu_tpu_req_vld_o);
    end
    exp_req_q.push_back(r);
    tick();
    disp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_tpu_req_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL single_req_vld got %b want 1", cpu_tpu_req_vld_o);
    end else begin
      e = exp_req_q.pop_front();
      exp_rd_q.push_back(e.insn[11:7]);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL single_payload got %h want %h", obs, e);
      end
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || cpu_tpu_req_vld_o !== 1'b0 || wb_vld_o !== 1'b0) begin
      errors++;
      $display("FAIL single_busy got busy=%b vld=%b wb=%b want 1 0 0", busy_o, cpu_tpu_req_vld_o, wb_vld_o);
    end
    tick();
    cpu_tpu_resp_vld_i  = 1'b1;
    cpu_tpu_resp_data_i = 32'hABCD;
    wb_rdy_i            = 1'b1;
    @(negedge clk);
    erd = exp_rd_q.pop_front();
    checks++;
    if (wb_vld_o !== 1'b1 || wb_rd_o !== erd || wb_data_o !== 32'hABCD || cpu_tpu_resp_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL single_wb got vld=%b rd=%0d data=%h rdy=%b want 1 %0d abcd 1", wb_vld_o, wb_rd_o, wb_data_o, cpu_tpu_resp_rdy_o, erd);
    end
    tick();
    cpu_tpu_resp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL single_busy_fall got %b want 0", busy_o);
    end
  endtask

  task automatic test_backpressure();
    cop_req_t r, e;
    tick();
    cpu_tpu_req_rdy_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      r = mk_req(1'b0, 5'(i + 1), 32'h100 + i);
      drive_disp(r);
      @(negedge clk);
      checks++;
      if (disp_rdy_o !== (i < 4)) begin
        errors++;
        $display("FAIL bp_disp_rdy[%0d] got %b want %b", i, disp_rdy_o, (i < 4));
      end
      if (i < 4) exp_req_q.push_back(r);
      tick();
    end
    disp_vld_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (cpu_tpu_req_vld_o !== 1'b1 || obs !== exp_req_q[0]) begin
        errors++;
        $display("FAIL bp_stable[%0d] got vld=%b %h want 1 %h", k, cpu_tpu_req_vld_o, obs, exp_req_q[0]);
      end
      tick();
    end
    cpu_tpu_req_rdy_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (cpu_tpu_req_vld_o !== 1'b1) begin
        errors++;
        $display("FAIL bp_drain_vld[%0d] got %b want 1", k, cpu_tpu_req_vld_o);
      end else begin
        e = exp_req_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL bp_drain_payload[%0d] got %h want %h", k, obs, e);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (cpu_tpu_req_vld_o !== 1'b0 || busy_o !== 1'b0 || disp_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle got vld=%b busy=%b rdy=%b want 0 0 1", cpu_tpu_req_vld_o, busy_o, disp_rdy_o);
    end
  endtask

  task automatic test_tag_full();
    cop_req_t r, e;
    logic [4:0] erd;
    logic [31:0] d;
    int fires;
    tick();
    cpu_tpu_req_rdy_i = 1'b1;
    wb_rdy_i          = 1'b1;
    fires             = 0;
    for (int c = 0; c < 12; c++) begin
      if (c < 5) begin
        r = mk_req(1'b1, 5'(c + 1), 32'h200 + c);
        drive_disp(r);
      end else begin
        disp_vld_i = 1'b0;
      end
      @(negedge clk);
      if (c < 5) exp_req_q.push_back(r);
      if (cpu_tpu_req_vld_o && cpu_tpu_req_rdy_i) begin
        fires++;
        e = exp_req_q.pop_front();
        exp_rd_q.push_back(e.insn[11:7]);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL tagfull_payload[%0d] got %h want %h", c, obs, e);
        end
      end
      tick();
    end
    disp_vld_i = 1'b0;
    checks++;
    if (fires != 4) begin
      errors++;
      $display("FAIL tagfull_fires got %0d want 4", fires);
    end
    @(negedge clk);
    checks++;
    if (cpu_tpu_req_vld_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL tagfull_held got vld=%b busy=%b want 0 1", cpu_tpu_req_vld_o, busy_o);
    end
    tick();
    d = $urandom;
    cpu_tpu_resp_vld_i  = 1'b1;
    cpu_tpu_resp_data_i = d;
    @(negedge clk);
    erd = exp_rd_q.pop_front();
    checks++;
    if (wb_vld_o !== 1'b1 || wb_rd_o !== erd || wb_data_o !== d) begin
      errors++;
      $display("FAIL tagfull_wb got vld=%b rd=%0d data=%h want 1 %0d %h", wb_vld_o, wb_rd_o, wb_data_o, erd, d);
    end
    tick();
    cpu_tpu_resp_vld_i = 1'b0;
    fires = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (cpu_tpu_req_vld_o && cpu_tpu_req_rdy_i) begin
        fires++;
        e = exp_req_q.pop_front();
        exp_rd_q.push_back(e.insn[11:7]);
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL tagfull_fifth_payload got %h want %h", obs, e);
        end
      end
      tick();
    end
    checks++;
    if (fires != 1) begin
      errors++;
      $display("FAIL tagfull_fifth_fires got %0d want 1", fires);
    end
    for (int k = 0; k < 4; k++) begin
      d = 32'hD000 + k;
      cpu_tpu_resp_vld_i  = 1'b1;
      cpu_tpu_resp_data_i = d;
      @(negedge clk);
      erd = exp_rd_q.pop_front();
      checks++;
      if (wb_vld_o !== 1'b1 || wb_rd_o !== erd || wb_data_o !== d) begin
        errors++;
        $display("FAIL tagfull_drain[%0d] got vld=%b rd=%0d data=%h want 1 %0d %h", k, wb_vld_o, wb_rd_o, wb_data_o, erd, d);
      end
      tick();
    end
    cpu_tpu_resp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL tagfull_idle got busy=%b want 0", busy_o);
    end
  endtask

  task automatic test_non_xd();
    cop_req_t r, e;
    int fires, wbseen;
    tick();
    cpu_tpu_req_rdy_i = 1'b1;
    fires  = 0;
    wbseen = 0;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        r = mk_req(1'b0, 5'(c + 9), 32'h300 + c);
        drive_disp(r);
      end else begin
        disp_vld_i = 1'b0;
      end
      @(negedge clk);
      if (c < 3) exp_req_q.push_back(r);
      if (wb_vld_o) wbseen++;
      if (cpu_tpu_req_vld_o && cpu_tpu_req_rdy_i) begin
        fires++;
        e = exp_req_q.pop_front();
        checks++;
        if (obs !== e) begin
          errors++;
          $display("FAIL nonxd_payload[%0d] got %h want %h", c, obs, e);
        end
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (fires != 3 || wbseen != 0 || busy_o !== 1'b0 || cpu_tpu_resp_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL nonxd_summary got fires=%0d wb=%0d busy=%b resp_rdy=%b want 3 0 0 1", fires, wbseen, busy_o, cpu_tpu_resp_rdy_o);
    end
  endtask

  task automatic test_spurious();
    tick();
    wb_rdy_i            = 1'b0;
    cpu_tpu_resp_vld_i  = 1'b1;
    cpu_tpu_resp_data_i = 32'hDEAD;
    @(negedge clk);
    checks++;
    if (cpu_tpu_resp_rdy_o !== 1'b1 || wb_vld_o !== 1'b0 || err_o !== 1'b0) begin
      errors++;
      $display("FAIL spurious_accept got rdy=%b wb=%b err=%b want 1 0 0", cpu_tpu_resp_rdy_o, wb_vld_o, err_o);
    end
    tick();
    cpu_tpu_resp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL spurious_err got %b want 1", err_o);
    end
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL spurious_sticky got %b want 1", err_o);
    end
  endtask

  task automatic test_timeout_reset();
    cop_req_t r, e;
    logic want_late;
`ifdef COP_ISSUER_TIMEOUT_EN
    want_late = 1'b1;
`else
    want_late = 1'b0;
`endif
    tick();
    wb_rdy_i          = 1'b1;
    cpu_tpu_req_rdy_i = 1'b1;
    r = mk_req(1'b1, 5'd7, 32'h400);
    drive_disp(r);
    @(negedge clk);
    exp_req_q.push_back(r);
    tick();
    disp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_tpu_req_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL to_req_vld got %b want 1", cpu_tpu_req_vld_o);
    end else begin
      e = exp_req_q.pop_front();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL to_payload got %h want %h", obs, e);
      end
    end
    tick();
    cpu_tpu_req_rdy_i = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (timeout_o !== 1'b0) begin
      errors++;
      $display("FAIL to_early got %b want 0", timeout_o);
    end
    repeat (10) tick();
    @(negedge clk);
    checks++;
    if (timeout_o !== want_late) begin
      errors++;
      $display("FAIL to_late got %b want %b", timeout_o, want_late);
    end
    tick();
    drive_disp(mk_req(1'b0, 5'd3, 32'h500));
    tick();
    disp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_o !== 1'b1 || cpu_tpu_req_vld_o !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre got busy=%b vld=%b want 1 1", busy_o, cpu_tpu_req_vld_o);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({disp_rdy_o, cpu_tpu_req_vld_o, cpu_tpu_resp_rdy_o, wb_vld_o, busy_o, err_o, timeout_o} !== 7'b1010000 || obs !== '0 || wb_rd_o !== 5'd0) begin
      errors++;
      $display("FAIL midrst_values got %b payload=%h rd=%0d want 1010000 0 0", {disp_rdy_o, cpu_tpu_req_vld_o, cpu_tpu_resp_rdy_o, wb_vld_o, busy_o, err_o, timeout_o}, obs, wb_rd_o);
    end
    tick();
    rst_n = 1'b1;
    exp_req_q.delete();
    exp_rd_q.delete();
    tick();
    cpu_tpu_resp_vld_i = 1'b1;
    @(negedge clk);
    checks++;
    if (wb_vld_o !== 1'b0 || cpu_tpu_resp_rdy_o !== 1'b1) begin
      errors++;
      $display("FAIL postrst_resp got wb=%b rdy=%b want 0 1", wb_vld_o, cpu_tpu_resp_rdy_o);
    end
    tick();
    cpu_tpu_resp_vld_i = 1'b0;
    @(negedge clk);
    checks++;
    if (err_o !== 1'b1) begin
      errors++;
      $display("FAIL postrst_err got %b want 1", err_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_xd();
    test_backpressure();
    test_tag_full();
    test_non_xd();
    test_spurious();
    test_timeout_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
